blake2s_block_sched: RTL and testbench
======================================

Name: blake2s_block_sched

Overview:
Sequences the BLAKE2s compression core from the byte stream emitted by the I/O interface. Tracks the byte position within each 64-byte block and derives the per-block flags and the 64-bit offset counter t. Issues one start per block, waits for completion, then streams the nn-byte digest back out. Sits between the I/O interface outputs and the compression core, and drives the interface ready and hash lines.

Parameters:
BLOCK_BYTES, 64, bytes per compression block; fixed for BLAKE2s.
NN_MAX, 32, maximum digest length in bytes.
T_W, 64, width of the offset counter t and of ll.

Ports:
clk  in  1  clock
nreset  in  1  reset, asynchronous, active-low
kk_i  in  6  key length in bytes, 0 = unkeyed
nn_i  in  6  digest length in bytes
ll_i  in  64  message length in bytes
data_v_i  in  1  byte strobe from the I/O interface
data_idx_i  in  6  byte index within the block
block_first_i  in  1  current block is the first block
block_last_i  in  1  current block is the last block
ready_v_o  out  1  scheduler accepts block bytes
cmp_start_o  out  1  one-cycle compression start pulse
cmp_first_o  out  1  initialise h from the parameter block; valid with cmp_start_o
cmp_last_o  out  1  final-block flag f0; valid with cmp_start_o
cmp_t_o  out  64  offset counter t; valid with cmp_start_o
cmp_done_i  in  1  one-cycle compression-complete pulse
hash_idx_o  out  5  digest byte select into the core h state
hash_byte_i  in  8  selected digest byte, combinational from the core
hash_v_o  out  1  digest byte valid
hash_o  out  8  digest byte
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync deassert): state IDLE; t_q=0; all outputs 0 except ready_v_o=1.
- Every block is delivered as 64 bytes. The host zero-pads the final and key blocks.
- FSM states: IDLE, FILL, START, COMPRESS, OUT.
- IDLE: ready_v_o=1.
  - data_v_i with data_idx_i=0: capture block_first_i and block_last_i into first_q/last_q, set exp_idx=1, go to FILL.
  - If block_first_i=1, t_q clears to 0.
- FILL: ready_v_o=1.
  - Each data_v_i increments exp_idx.
  - data_v_i with data_idx_i=63: go to START next cycle.
- START: exactly one cycle with cmp_start_o=1.
  - cmp_first_o=first_q, cmp_last_o=last_q.
  - cmp_t_o = last_q ? ll_i + (kk_i!=0 ? 64 : 0) : t_q+64. The adds are 64-bit and wrap mod 2^64.
  - Non-last block: t_q <= t_q+64.
  - Go to COMPRESS. ready_v_o=0 from START onward.
- COMPRESS: ready_v_o=0; wait for cmp_done_i.
  - On cmp_done_i: last_q=1 goes to OUT with hash_idx_o=0; last_q=0 goes to IDLE.
- OUT: ready_v_o=0.
  - Each cycle: hash_idx_o increments; hash_v_o<=1 and hash_o<=hash_byte_i, both registered, 1-cycle latency from hash_idx_o.
  - Byte count n_eff = (nn_i==0 or nn_i>NN_MAX) ? 32 : nn_i.
  - After n_eff bytes go to IDLE. hash_v_o is high for exactly n_eff consecutive cycles.
- Config (kk_i, nn_i, ll_i) is sampled live. It must be stable from the first block's start through the end of OUT.
- err_o is sticky until reset. It sets on any of:
  - data_v_i while ready_v_o=0; the byte is ignored and the FSM is unaffected.
  - data_idx_i != exp_idx in FILL; the FSM continues on data_idx_i.
  - data_v_i in IDLE with data_idx_i != 0; the byte is ignored.
  - cmp_done_i outside COMPRESS; the pulse is ignored.
- Simultaneous events:
  - cmp_done_i in the same cycle as the START pulse is ignored; done is only sampled in COMPRESS.
  - data_v_i on the cycle OUT returns to IDLE is treated as an IDLE byte.
- Reset mid-operation (any state) returns to IDLE immediately. Any in-flight compression result is discarded and no hash bytes are emitted.

Test Plan:
- Unkeyed single block: kk=0, nn=32, ll=3, bytes idx 0..63 with first=last=1.
  - cmp_start_o one pulse 1 cycle after idx 63, first=1, last=1, t=3.
  - cmp_done_i gives 32 hash_v_o cycles, with hash_o matching hash_byte_i at idx 0..31.
- Keyed two-block: kk=16, ll=10.
  - Block 1 (first=1, last=0): t=64.
  - Block 2 (last=1): t=74, first=0.
  - Only the second done produces output.
- Three-block message, kk=0, ll=150: starts carry t=64, 128, then 150; ready_v_o is low from START through done on each block.
- Digest length clamp:
  - nn=0 gives 32 output bytes.
  - nn=20 gives exactly 20 bytes, idx 0..19, then ready_v_o=1.
- Protocol errors:
  - data_v_i during COMPRESS sets err_o=1 and t/state are unchanged.
  - idx 5 following idx 3 sets err_o.
  - Stray cmp_done_i in IDLE sets err_o and no OUT occurs.
- Reset mid-OUT after 7 bytes: hash_v_o=0 the same cycle as the nreset assertion, then state is IDLE, ready_v_o=1, t_q=0.

Source files
------------

// File: rtl/blake2s_block_sched_if.sv
// Bundles the scheduler's block-input, compression-core and digest-output signals.
// The scheduler takes the master view; the surrounding I/O logic and core take the slave view.
interface blake2s_block_sched_if;
  logic [5:0]  kk_i;
  logic [5:0]  nn_i;
  logic [63:0] ll_i;
  logic        data_v_i;
  logic [5:0]  data_idx_i;
  logic        block_first_i;
  logic        block_last_i;
  logic        ready_v_o;
  logic        cmp_start_o;
  logic        cmp_first_o;
  logic        cmp_last_o;
  logic [63:0] cmp_t_o;
  logic        cmp_done_i;
  logic [4:0]  hash_idx_o;
  logic [7:0]  hash_byte_i;
  logic        hash_v_o;
  logic [7:0]  hash_o;
  logic        err_o;

  modport master (
    input  kk_i, nn_i, ll_i, data_v_i, data_idx_i, block_first_i, block_last_i,
    input  cmp_done_i, hash_byte_i,
    output ready_v_o, cmp_start_o, cmp_first_o, cmp_last_o, cmp_t_o,
    output hash_idx_o, hash_v_o, hash_o, err_o
  );

  modport slave (
    output kk_i, nn_i, ll_i, data_v_i, data_idx_i, block_first_i, block_last_i,
    output cmp_done_i, hash_byte_i,
    input  ready_v_o, cmp_start_o, cmp_first_o, cmp_last_o, cmp_t_o,
    input  hash_idx_o, hash_v_o, hash_o, err_o
  );
endinterface

// File: rtl/blake2s_block_sched.sv
// BLAKE2s block scheduler: counts block bytes, launches one compression per block
// with first/last flags and offset t, then streams the clamped digest out.
module blake2s_block_sched #(
  parameter int BLOCK_BYTES = 64,
  parameter int NN_MAX      = 32,
  parameter int T_W         = 64
) (
  input  logic                    clk,
  input  logic                    nreset,
  blake2s_block_sched_if.master   bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_COMPRESS = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  localparam logic [5:0]     LAST_IDX = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0]     NN_CLAMP = 6'(NN_MAX);
  localparam logic [T_W-1:0] BLK_T    = T_W'(BLOCK_BYTES);

  logic [2:0]     state_q, state_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic [5:0]     exp_idx_q, exp_idx_d;
  logic [T_W-1:0] t_q, t_d;
  logic [4:0]     hash_idx_q, hash_idx_d;
  logic           hash_v_q, hash_v_d;
  logic [7:0]     hash_q, hash_d;
  logic           err_q, err_d;

  logic           ready;
  logic           in_start;
  logic [5:0]     n_eff;
  logic [T_W-1:0] t_last;

  assign ready    = (state_q == S_IDLE) || (state_q == S_FILL);
  assign in_start = (state_q == S_START);
  assign n_eff    = ((bus.nn_i == 6'd0) || (bus.nn_i > NN_CLAMP)) ? NN_CLAMP : bus.nn_i;
  // The final block's t is the whole message length, plus one block when a key block was prepended.
  assign t_last   = bus.ll_i + ((bus.kk_i != 6'd0) ? BLK_T : '0);

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    last_d     = last_q;
    exp_idx_d  = exp_idx_q;
    t_d        = t_q;
    hash_idx_d = hash_idx_q;
    hash_v_d   = 1'b0;
    hash_d     = '0;
    err_d      = err_q;

    if (bus.data_v_i && !ready) err_d = 1'b1;
    if (bus.cmp_done_i && (state_q != S_COMPRESS)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.data_v_i) begin
          if (bus.data_idx_i == 6'd0) begin
            first_d   = bus.block_first_i;
            last_d    = bus.block_last_i;
            exp_idx_d = 6'd1;
            state_d   = S_FILL;
            if (bus.block_first_i) t_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (bus.data_v_i) begin
          if (bus.data_idx_i != exp_idx_q) err_d = 1'b1;
          // Resynchronise on the index actually seen so one glitch does not stall the block.
          exp_idx_d = bus.data_idx_i + 6'd1;
          if (bus.data_idx_i == LAST_IDX) state_d = S_START;
        end
      end
      S_START: begin
        if (!last_q) t_d = t_q + BLK_T;
        state_d = S_COMPRESS;
      end
      S_COMPRESS: begin
        if (bus.cmp_done_i) begin
          hash_idx_d = 5'd0;
          state_d    = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        hash_v_d   = 1'b1;
        hash_d     = bus.hash_byte_i;
        hash_idx_d = hash_idx_q + 5'd1;
        if ({1'b0, hash_idx_q} == (n_eff - 6'd1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      exp_idx_q  <= '0;
      t_q        <= '0;
      hash_idx_q <= '0;
      hash_v_q   <= 1'b0;
      hash_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      last_q     <= last_d;
      exp_idx_q  <= exp_idx_d;
      t_q        <= t_d;
      hash_idx_q <= hash_idx_d;
      hash_v_q   <= hash_v_d;
      hash_q     <= hash_d;
      err_q      <= err_d;
    end
  end

  assign bus.ready_v_o   = ready;
  assign bus.cmp_start_o = in_start;
  assign bus.cmp_first_o = in_start & first_q;
  assign bus.cmp_last_o  = in_start & last_q;
  assign bus.cmp_t_o     = in_start ? (last_q ? t_last : t_q + BLK_T) : '0;
  assign bus.hash_idx_o  = hash_idx_q;
  assign bus.hash_v_o    = hash_v_q;
  assign bus.hash_o      = hash_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_blake2s_block_sched.sv
// Randomized scoreboard bench for blake2s_block_sched: expected starts and digest bytes
// are queued at stimulus time and checked by an independent monitor.
module tb_blake2s_block_sched;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [7:0] seed = 8'h00;

  blake2s_block_sched_if bus();

  blake2s_block_sched dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the core's h state: each digest byte is a fixed function of its index.
  function automatic logic [7:0] hash_model(input logic [4:0] i, input logic [7:0] s);
    return s ^ (8'(i) * 8'd37 + 8'd11);
  endfunction

  assign bus.hash_byte_i = hash_model(bus.hash_idx_o, seed);

  typedef struct packed {
    logic        first;
    logic        last;
    logic [63:0] t;
  } start_t;

  start_t     start_q[$];
  logic [7:0] hash_exp_q[$];
  int checks = 0;
  int errors = 0;
  int hash_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output with nothing expected", name);
  endtask

  // Monitor: pops and compares whenever the DUT presents a start pulse or digest byte.
  always @(negedge clk) begin
    start_t     e;
    logic [7:0] hb;
    if (nreset) begin
      if (bus.cmp_start_o) begin
        if (start_q.size() == 0) unexpected("start_unexpected");
        else begin
          e = start_q.pop_front();
          chk("cmp_first", 64'(bus.cmp_first_o), 64'(e.first));
          chk("cmp_last", 64'(bus.cmp_last_o), 64'(e.last));
          chk("cmp_t", bus.cmp_t_o, e.t);
          $display("start first=%0d last=%0d t=%0d", bus.cmp_first_o, bus.cmp_last_o, bus.cmp_t_o);
        end
      end
      if (bus.hash_v_o) begin
        hash_seen++;
        if (hash_exp_q.size() == 0) unexpected("hash_unexpected");
        else begin
          hb = hash_exp_q.pop_front();
          chk("hash_byte", 64'(bus.hash_o), 64'(hb));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic first, input logic last, input bit skip4);
    for (int i = 0; i < 64; i++) begin
      if (!(skip4 && i == 4)) begin
        bus.data_v_i      = 1'b1;
        bus.data_idx_i    = 6'(i);
        bus.block_first_i = first;
        bus.block_last_i  = last;
        tick();
      end
    end
    bus.data_v_i = 1'b0;
  endtask

  // Emulated compression core; optionally injects a stray byte while compressing.
  task automatic core_respond(input bit inject);
    int d;
    d = inject ? 3 : int'($urandom_range(1, 4));
    chk("ready_start", 64'(bus.ready_v_o), 64'd0);
    for (int k = 0; k < d; k++) begin
      tick();
      chk("ready_compress", 64'(bus.ready_v_o), 64'd0);
      if (inject && k == 0) begin
        bus.data_v_i      = 1'b1;
        bus.data_idx_i    = 6'd0;
        bus.block_first_i = 1'b1;
      end else begin
        bus.data_v_i = 1'b0;
      end
    end
    bus.cmp_done_i = 1'b1;
    tick();
    bus.cmp_done_i = 1'b0;
  endtask

  function automatic int n_eff(input logic [5:0] nn);
    return (nn == 0 || nn > 32) ? 32 : int'(nn);
  endfunction

  // Queues the expected start for block b of nb and, for the last block, the digest.
  task automatic expect_block(input int b, input int nb, input logic [5:0] kk,
                              input logic [5:0] nn, input logic [63:0] ll);
    start_t e;
    e.first = (b == 1);
    e.last  = (b == nb);
    e.t     = (b == nb) ? ll + ((kk != 0) ? 64'd64 : 64'd0) : 64'(b) * 64'd64;
    start_q.push_back(e);
    if (b == nb)
      for (int i = 0; i < n_eff(nn); i++) hash_exp_q.push_back(hash_model(5'(i), seed));
  endtask

  task automatic message(input logic [5:0] kk, input logic [5:0] nn, input logic [63:0] ll,
                         input int nb, input bit inject, input int skip_blk);
    bus.kk_i = kk;
    bus.nn_i = nn;
    bus.ll_i = ll;
    seed     = 8'($urandom);
    for (int b = 1; b <= nb; b++) begin
      expect_block(b, nb, kk, nn, ll);
      send_block(b == 1, b == nb, skip_blk == b);
      core_respond(inject && b == 1);
    end
    for (int c = 0; c < 100 && hash_exp_q.size() != 0; c++) tick();
    chk("digest_drain", 64'(hash_exp_q.size()), 64'd0);
    chk("hash_v_after", 64'(bus.hash_v_o), 64'd0);
    chk("ready_after", 64'(bus.ready_v_o), 64'd1);
    $display("digest kk=%0d nn=%0d ll=%0d blocks=%0d bytes=%0d", kk, nn, ll, nb, n_eff(nn));
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    start_q.delete();
    hash_exp_q.delete();
    tick();
    tick();
    nreset = 1'b1;
    tick();
  endtask

  initial begin
    int base;
    bus.kk_i = '0; bus.nn_i = '0; bus.ll_i = '0;
    bus.data_v_i = 1'b0; bus.data_idx_i = '0;
    bus.block_first_i = 1'b0; bus.block_last_i = 1'b0;
    bus.cmp_done_i = 1'b0;
    tick();
    chk("rst_ready", 64'(bus.ready_v_o), 64'd1);
    chk("rst_start", 64'(bus.cmp_start_o), 64'd0);
    chk("rst_hash_v", 64'(bus.hash_v_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_cmp_t", bus.cmp_t_o, 64'd0);
    tick();
    nreset = 1'b1;
    tick();

    message(6'd0, 6'd32, 64'd3, 1, 0, 0);
    message(6'd16, 6'd32, 64'd10, 2, 0, 0);
    message(6'd0, 6'd32, 64'd150, 3, 0, 0);
    message(6'd0, 6'd0, 64'd100, 2, 0, 0);
    message(6'd0, 6'd20, 64'd5, 1, 0, 0);
    message(6'd8, 6'd32, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 0);
    for (int m = 0; m < 12; m++) begin
      logic [5:0]  kk;
      logic [63:0] ll;
      kk = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(1, 32)) : 6'd0;
      ll = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
      message(kk, 6'($urandom_range(0, 40)), ll, int'($urandom_range(1, 4)), 0, 0);
    end
    chk("err_clean", 64'(bus.err_o), 64'd0);

    // Byte during compression: flagged, and block 2 still sees t=128.
    message(6'd0, 6'd32, 64'd200, 3, 1, 0);
    chk("err_data_compress", 64'(bus.err_o), 64'd1);

    do_reset();
    chk("err_cleared", 64'(bus.err_o), 64'd0);
    message(6'd0, 6'd32, 64'd64, 1, 0, 1);
    chk("err_idx_skip", 64'(bus.err_o), 64'd1);

    do_reset();
    bus.cmp_done_i = 1'b1;
    tick();
    bus.cmp_done_i = 1'b0;
    repeat (5) tick();
    chk("err_stray_done", 64'(bus.err_o), 64'd1);
    chk("ready_stray_done", 64'(bus.ready_v_o), 64'd1);

    // Reset partway through the digest of a three-block message.
    do_reset();
    bus.kk_i = 6'd0; bus.nn_i = 6'd32; bus.ll_i = 64'd150;
    seed = 8'($urandom);
    for (int b = 1; b <= 3; b++) begin
      expect_block(b, 3, 6'd0, 6'd32, 64'd150);
      send_block(b == 1, b == 3, 0);
      core_respond(0);
    end
    base = hash_seen - 7;
    for (int c = 0; c < 100 && hash_seen < base + 14; c++) tick();
    chk("bytes_before_reset", 64'(hash_seen - base), 64'd14);
    nreset = 1'b0;
    #1;
    chk("hash_v_in_reset", 64'(bus.hash_v_o), 64'd0);
    chk("ready_in_reset", 64'(bus.ready_v_o), 64'd1);
    hash_exp_q.delete();
    start_q.delete();
    tick();
    tick();
    nreset = 1'b1;
    repeat (4) tick();
    start_q.push_back('{first: 1'b0, last: 1'b0, t: 64'd64});
    send_block(1'b0, 1'b0, 0);
    core_respond(0);
    repeat (3) tick();
    chk("start_drain", 64'(start_q.size()), 64'd0);
    chk("hash_drain_end", 64'(hash_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
